// File: rtl/tube_scan_ctrl.sv
// rtl/tube_scan_ctrl.sv - memory-mapped multi-group 7-segment scan controller
// Shared 4-slot digit scan with PWM brightness, per-digit blanking and an aux sign/hex digit.
module tube_scan_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_7f38,
    parameter int          NUM_GRP     = 2,
    parameter int          SCAN_CNT    = 15000,
    parameter bit          SEG_ACT_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [31:0]          addr,
    input  logic [31:0]          wd,
    output logic [31:0]          rd,
    output logic [8*NUM_GRP-1:0] seg,
    output logic [4*NUM_GRP-1:0] sel,
    output logic [7:0]           seg_aux,
    output logic                 sel_aux
);

    localparam int         CW       = $clog2(SCAN_CNT);
    localparam logic [7:0] SEG_XOR  = SEG_ACT_LOW ? 8'h00 : 8'hFF;
    localparam logic [7:0] SEG_OFF  = 8'hFF ^ SEG_XOR;
    localparam logic [7:0] SEG_MIN  = 8'hFE ^ SEG_XOR;
    localparam logic [31:0] CTRL_RST = 32'h0000_00F1;

    logic [31:0]          data_lo_q, data_hi_q, ctrl_q;
    logic [3:0]           aux_q;
    logic [CW-1:0]        cnt_q;
    logic [1:0]           idx_q;
    logic [3:0]           pwm_q;
    logic [8*NUM_GRP-1:0] seg_q;
    logic [4*NUM_GRP-1:0] sel_q;
    logic [7:0]           seg_aux_q;
    logic                 sel_aux_q;

    logic        hit_d;
    logic        lit_d;
    logic [63:0] data_all_d;

    function automatic logic [7:0] enc(input logic [3:0] n);
        case (n)
            4'h0: enc = 8'h81; 4'h1: enc = 8'hCF; 4'h2: enc = 8'h92; 4'h3: enc = 8'h86;
            4'h4: enc = 8'hCC; 4'h5: enc = 8'hA4; 4'h6: enc = 8'hA0; 4'h7: enc = 8'h8F;
            4'h8: enc = 8'h80; 4'h9: enc = 8'h84; 4'hA: enc = 8'h88; 4'hB: enc = 8'hE0;
            4'hC: enc = 8'hB1; 4'hD: enc = 8'hC2; 4'hE: enc = 8'hB0; default: enc = 8'hB8;
        endcase
    endfunction

    // 33-bit compare so a window near the top of the address space cannot wrap
    always_comb begin
        hit_d      = ({1'b0, addr} >= {1'b0, BASE_ADDR}) &&
                     ({1'b0, addr} <  ({1'b0, BASE_ADDR} + 33'd16));
        lit_d      = ctrl_q[0] && (pwm_q <= ctrl_q[7:4]);
        data_all_d = {data_hi_q, data_lo_q};
    end

    always_comb begin
        rd = 32'hFFFF_FFFF;
        if (hit_d) begin
            case (addr[3:2])
                2'd0:    rd = data_lo_q;
                2'd1:    rd = (NUM_GRP > 2) ? data_hi_q : 32'h0;
                2'd2:    rd = ctrl_q;
                default: rd = {28'h0, aux_q};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_lo_q <= 32'h0;
            data_hi_q <= 32'h0;
            ctrl_q    <= CTRL_RST;
            aux_q     <= 4'h0;
            cnt_q     <= CW'(SCAN_CNT - 1);
            idx_q     <= 2'd0;
            pwm_q     <= 4'd0;
            seg_q     <= {NUM_GRP{SEG_OFF}};
            sel_q     <= '0;
            seg_aux_q <= SEG_OFF;
            sel_aux_q <= 1'b0;
        end else begin
            if (we && hit_d) begin
                case (addr[3:2])
                    2'd0: data_lo_q <= wd;
                    2'd1: if (NUM_GRP > 2) data_hi_q <= wd;
                    2'd2: ctrl_q <= wd & 32'hFFFF_00F3;
                    default: aux_q <= wd[3:0];
                endcase
            end

            // scan timing is independent of bus activity
            if (cnt_q == '0) begin
                cnt_q <= CW'(SCAN_CNT - 1);
                idx_q <= idx_q + 2'd1;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
            pwm_q <= pwm_q + 4'd1;

            for (int g = 0; g < NUM_GRP; g++) begin
                sel_q[4*g +: 4] <= lit_d ? (4'b0001 << idx_q) : 4'b0000;
                if (lit_d && !ctrl_q[16 + 4*g + int'(idx_q)])
                    seg_q[8*g +: 8] <= enc(data_all_d[16*g + 4*int'(idx_q) +: 4]) ^ SEG_XOR;
                else
                    seg_q[8*g +: 8] <= SEG_OFF;
            end

            sel_aux_q <= lit_d;
            if (!lit_d)
                seg_aux_q <= SEG_OFF;
            else if (ctrl_q[1] && data_lo_q[31])
                seg_aux_q <= SEG_MIN;
            else
                seg_aux_q <= enc(aux_q) ^ SEG_XOR;
        end
    end

    assign seg     = seg_q;
    assign sel     = sel_q;
    assign seg_aux = seg_aux_q;
    assign sel_aux = sel_aux_q;

endmodule

// File: tb/tb_tube_scan_ctrl.sv
// tb/tb_tube_scan_ctrl.sv - self-checking bench for tube_scan_ctrl
// Reference derives scan slot and PWM phase from the cycle count since reset.
module tb_tube_scan_ctrl;

    localparam logic [31:0] BASE = 32'h0000_7f38;
    localparam int          NG   = 2;
    localparam int          SC   = 4;
    localparam logic [7:0]  ENC [16] = '{8'h81, 8'hCF, 8'h92, 8'h86, 8'hCC, 8'hA4, 8'hA0, 8'h8F,
                                         8'h80, 8'h84, 8'h88, 8'hE0, 8'hB1, 8'hC2, 8'hB0, 8'hB8};

    logic        clk = 1'b0;
    logic        reset, we;
    logic [31:0] addr, wd, rd;
    logic [15:0] seg;
    logic [7:0]  sel, seg_aux;
    logic        sel_aux;

    always #5 clk = ~clk;

    tube_scan_ctrl #(.BASE_ADDR(BASE), .NUM_GRP(NG), .SCAN_CNT(SC), .SEG_ACT_LOW(1'b1)) dut (
        .clk(clk), .reset(reset), .we(we), .addr(addr), .wd(wd), .rd(rd),
        .seg(seg), .sel(sel), .seg_aux(seg_aux), .sel_aux(sel_aux)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_lo, m_ctrl;
    logic [3:0]  m_aux;
    int          t;
    int          lit_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic bit in_win(input logic [31:0] a);
        longint la, lb;
        la = longint'(a);
        lb = longint'(BASE);
        return (la >= lb) && (la < lb + 16);
    endfunction

    function automatic logic [31:0] word_addr(input int k);
        logic [31:0] a;
        word_addr = BASE;
        for (int i = 0; i < 4; i++) begin
            a = BASE + 32'(4 * i);
            if (int'(a[3:2]) == k) word_addr = a;
        end
    endfunction

    task automatic m_reset();
        m_lo = 32'h0; m_ctrl = 32'h0000_00F1; m_aux = 4'h0; t = 0;
    endtask

    task automatic cyc(input bit rst, input bit w, input logic [31:0] a, input logic [31:0] d);
        logic [7:0]  e_sel, e_aux;
        logic [15:0] e_seg;
        logic        e_sela;
        logic [31:0] e_rd;
        logic [3:0]  nib;
        int          idx, pwm;
        bit          lit;
        reset = rst; we = w; addr = a; wd = d;
        idx = (t / SC) % 4;
        pwm = t % 16;
        lit = m_ctrl[0] && (pwm <= int'(m_ctrl[7:4]));
        for (int g = 0; g < NG; g++) begin
            e_sel[4*g +: 4] = lit ? (4'b0001 << idx) : 4'b0000;
            nib = m_lo[16*g + 4*idx +: 4];
            e_seg[8*g +: 8] = (lit && !m_ctrl[16 + 4*g + idx]) ? ENC[nib] : 8'hFF;
        end
        e_sela = lit;
        e_aux  = !lit ? 8'hFF : ((m_ctrl[1] && m_lo[31]) ? 8'hFE : ENC[m_aux]);
        if (rst) begin
            e_sel = 8'h00; e_seg = 16'hFFFF; e_aux = 8'hFF; e_sela = 1'b0;
        end
        @(posedge clk);
        #1;
        check("sel", 32'(sel), 32'(e_sel));
        check("seg", 32'(seg), 32'(e_seg));
        check("seg_aux", 32'(seg_aux), 32'(e_aux));
        check("sel_aux", 32'(sel_aux), 32'(e_sela));
        if (sel[3:0] != 4'h0) lit_cnt++;
        if (rst) m_reset();
        else begin
            if (w && in_win(a)) begin
                case (a[3:2])
                    2'd0: m_lo = d;
                    2'd2: m_ctrl = d;
                    2'd3: m_aux = d[3:0];
                    default: ;
                endcase
            end
            t++;
        end
        if (!in_win(a) || a[3:2] != 2'd2) begin
            if (!in_win(a)) e_rd = 32'hFFFF_FFFF;
            else if (a[3:2] == 2'd0) e_rd = m_lo;
            else if (a[3:2] == 2'd1) e_rd = 32'h0;
            else e_rd = {28'h0, m_aux};
            check("rd", rd, e_rd);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, word_addr(0), 32'h0);
    endtask

    initial begin
        logic [31:0] a, d;
        int          r, k;
        reset = 1'b1; we = 1'b0; addr = 32'h0; wd = 32'h0;
        m_reset();
        cyc(1'b1, 1'b0, word_addr(0), 32'h0);
        cyc(1'b1, 1'b0, BASE + 32'd16, 32'h0);
        idle(20);

        cyc(1'b0, 1'b1, word_addr(0), 32'h8765_4321);
        idle(18);

        for (int i = 0; i < 24; i++) cyc(1'b0, 1'b1, word_addr(0), $urandom);

        cyc(1'b0, 1'b1, word_addr(2), 32'h0000_0031);
        lit_cnt = 0;
        idle(16);
        check("duty_bright3", 32'(lit_cnt), 32'd4);
        cyc(1'b0, 1'b1, word_addr(2), 32'h0000_00F0);
        lit_cnt = 0;
        idle(16);
        check("duty_en0", 32'(lit_cnt), 32'd0);

        cyc(1'b0, 1'b1, word_addr(2), 32'h0004_00F1);
        idle(18);

        cyc(1'b0, 1'b1, word_addr(0), 32'h8000_0000);
        cyc(1'b0, 1'b1, word_addr(2), 32'h0000_00F3);
        idle(6);
        cyc(1'b0, 1'b1, word_addr(0), 32'h0000_0000);
        cyc(1'b0, 1'b1, word_addr(3), 32'hFFFF_FFFA);
        idle(6);
        cyc(1'b0, 1'b0, BASE + 32'd16, 32'h0);
        cyc(1'b0, 1'b1, BASE - 32'd1, 32'h1234_5678);
        cyc(1'b0, 1'b1, word_addr(1), 32'hDEAD_BEEF);

        idle(5);
        cyc(1'b1, 1'b0, word_addr(0), 32'h0);
        idle(6);

        for (int i = 0; i < 900; i++) begin
            r = $urandom_range(0, 99);
            k = $urandom_range(0, 9);
            if (k < 8) a = word_addr(k % 4) + 32'($urandom_range(0, 3));
            else if (k == 8) a = BASE - 32'($urandom_range(1, 4));
            else a = BASE + 32'd16 + 32'($urandom_range(0, 3));
            d = $urandom;
            if (a[3:2] == 2'd2) d[0] = ($urandom_range(0, 3) != 0);
            cyc(r < 2, r < 35, a, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
